// File: rtl/link_pkg.sv
// Shared types and constants for the link_peer serial partner.
package link_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PASSIVE = 3'd1,
    S_ACT_LO  = 3'd2,
    S_ACT_HI  = 3'd3,
    S_DONE    = 3'd4
  } link_state_e;

  localparam logic [7:0]  IDLE_BYTE = 8'hFF;
  localparam int unsigned BITCNT_W  = 4;

  // Shift one bit into the LSB of a byte, MSB falls out.
  function automatic logic [7:0] shift_in(input logic [7:0] b, input logic bit_i);
    return {b[6:0], bit_i};
  endfunction

endpackage

// File: rtl/link_fifo.sv
// Synchronous byte FIFO with registered head data, valid and full flags.
module link_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, full_q;
  logic             wr_en, rd_en;

  // Pointer advance and next head selection (bypass when writing the new head slot).
  always_comb begin
    wr_en  = push_i && !full_q;
    rd_en  = pop_i && valid_q;
    wptr_d = wptr_q + PW'(wr_en);
    rptr_d = rptr_q + PW'(rd_en);
    if (wr_en && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) begin
      dout_d = din_i;
    end else begin
      dout_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  // Pointers and registered status/head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      dout_q  <= dout_d;
      valid_q <= (wptr_d != rptr_d);
      full_q  <= (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;

endmodule

// File: rtl/link_peer.sv
// Far-end partner console for the Game Boy serial link.
// Passive when the console clocks, active (drives gb_clk_in) otherwise.
// Optional macro LINK_PEER_TIMEOUT_EN: abort a stalled passive byte.
module link_peer
  import link_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 511,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gb_clk_out,
  input  logic       gb_data_out,
  input  logic       gb_int_clock,
  output logic       gb_clk_in,
  output logic       gb_data_in,
  input  logic       go,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overflow,
  output logic       busy
);

  localparam int unsigned HALF   = (CLK_DIV + 1) / 2;
  localparam int unsigned HALF_W = (HALF > 1) ? $clog2(HALF) : 1;

  link_state_e         state_q, state_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [7:0]          shreg_q, shreg_d;
  logic [7:0]          rx_sh_q, rx_sh_d;
  logic [7:0]          tx_hold_q, tx_hold_d;
  logic                tx_hold_valid_q, tx_hold_valid_d;
  logic                gb_clk_in_q, gb_clk_in_d;
  logic                gb_data_in_q, gb_data_in_d;
  logic                rx_overflow_q, rx_overflow_d;
  logic                busy_q;
  logic [2:0]          clk_sync_q;
  logic [1:0]          dat_sync_q;
  logic                clk_rise, clk_fall, gb_data_s;
  logic                push_c, fifo_full;
  logic [7:0]          start_byte;

`ifdef LINK_PEER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  // Two-flop synchronisers; third clock stage is the edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], gb_clk_out};
      dat_sync_q <= {dat_sync_q[0], gb_data_out};
    end
  end

  assign clk_rise  = clk_sync_q[1] & ~clk_sync_q[2];
  assign clk_fall  = ~clk_sync_q[1] & clk_sync_q[2];
  assign gb_data_s = dat_sync_q[1];

  // Next-state and datapath for the transfer FSM.
  always_comb begin
    state_d         = state_q;
    bitcnt_d        = bitcnt_q;
    half_d          = half_q;
    shreg_d         = shreg_q;
    rx_sh_d         = rx_sh_q;
    tx_hold_d       = tx_hold_q;
    tx_hold_valid_d = tx_hold_valid_q;
    gb_clk_in_d     = gb_clk_in_q;
    gb_data_in_d    = gb_data_in_q;
    rx_overflow_d   = 1'b0;
    push_c          = 1'b0;
    start_byte      = tx_hold_valid_q ? tx_hold_q : IDLE_BYTE;
`ifdef LINK_PEER_TIMEOUT_EN
    to_cnt_d        = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        gb_clk_in_d  = 1'b1;
        gb_data_in_d = tx_hold_valid_q ? tx_hold_q[7] : 1'b1;
        if (gb_int_clock && clk_fall) begin
          state_d         = S_PASSIVE;
          bitcnt_d        = '0;
          shreg_d         = start_byte;
          gb_data_in_d    = start_byte[7];
          tx_hold_valid_d = 1'b0;
        end else if (!gb_int_clock && go) begin
          // First pulse presents bit 7 immediately; shreg is pre-shifted.
          state_d         = S_ACT_LO;
          bitcnt_d        = '0;
          half_d          = HALF_W'(HALF - 1);
          gb_clk_in_d     = 1'b0;
          gb_data_in_d    = start_byte[7];
          shreg_d         = shift_in(start_byte, 1'b1);
          tx_hold_valid_d = 1'b0;
        end
      end

      S_PASSIVE: begin
        if (clk_rise) begin
          rx_sh_d      = shift_in(rx_sh_q, gb_data_s);
          shreg_d      = shift_in(shreg_q, 1'b1);
          gb_data_in_d = shreg_q[6];
          bitcnt_d     = bitcnt_q + BITCNT_W'(1);
          if (bitcnt_q == BITCNT_W'(7)) begin
            state_d = S_DONE;
          end
        end
`ifdef LINK_PEER_TIMEOUT_EN
        if (clk_rise || clk_fall) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d      = S_IDLE;
          gb_data_in_d = 1'b1;
          to_cnt_d     = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end

      S_ACT_LO: begin
        if (half_q == '0) begin
          state_d     = S_ACT_HI;
          gb_clk_in_d = 1'b1;
          half_d      = HALF_W'(HALF - 1);
        end else begin
          half_d = half_q - HALF_W'(1);
        end
      end

      S_ACT_HI: begin
        if (half_q == '0) begin
          // bitcnt counts completed pulses; the 9th pulse only closes the byte.
          half_d   = HALF_W'(HALF - 1);
          bitcnt_d = bitcnt_q + BITCNT_W'(1);
          if (bitcnt_q == BITCNT_W'(8)) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_ACT_LO;
            gb_clk_in_d = 1'b0;
            rx_sh_d     = shift_in(rx_sh_q, gb_data_s);
            if (bitcnt_q <= BITCNT_W'(6)) begin
              gb_data_in_d = shreg_q[7];
              shreg_d      = shift_in(shreg_q, 1'b1);
            end
          end
        end else begin
          half_d = half_q - HALF_W'(1);
        end
      end

      S_DONE: begin
        push_c        = 1'b1;
        rx_overflow_d = fifo_full;
        gb_data_in_d  = 1'b1;
        gb_clk_in_d   = 1'b1;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Host byte accept; placed after the FSM so a same-cycle start keeps the new byte.
    if (tx_valid && !tx_hold_valid_q) begin
      tx_hold_d       = tx_data;
      tx_hold_valid_d = 1'b1;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      bitcnt_q        <= '0;
      half_q          <= '0;
      shreg_q         <= IDLE_BYTE;
      rx_sh_q         <= '0;
      tx_hold_q       <= '0;
      tx_hold_valid_q <= 1'b0;
      gb_clk_in_q     <= 1'b1;
      gb_data_in_q    <= 1'b1;
      rx_overflow_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      bitcnt_q        <= bitcnt_d;
      half_q          <= half_d;
      shreg_q         <= shreg_d;
      rx_sh_q         <= rx_sh_d;
      tx_hold_q       <= tx_hold_d;
      tx_hold_valid_q <= tx_hold_valid_d;
      gb_clk_in_q     <= gb_clk_in_d;
      gb_data_in_q    <= gb_data_in_d;
      rx_overflow_q   <= rx_overflow_d;
      busy_q          <= (state_d != S_IDLE);
    end
  end

`ifdef LINK_PEER_TIMEOUT_EN
  // Passive idle watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  link_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .din_i   (rx_sh_q),
    .pop_i   (rx_ready),
    .dout_o  (rx_data),
    .valid_o (rx_valid),
    .full_o  (fifo_full)
  );

  assign gb_clk_in   = gb_clk_in_q;
  assign gb_data_in  = gb_data_in_q;
  assign tx_ready    = ~tx_hold_valid_q;
  assign rx_overflow = rx_overflow_q;
  assign busy        = busy_q;

endmodule
